// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-port memory arbiter: FSM states, requester
// indices and the one-hot to index helper.
package mem_port_arbiter_pkg;

  localparam int unsigned NREQ = 3;

  localparam logic [1:0] REQ_CACHE = 2'd0;
  localparam logic [1:0] REQ_STORE = 2'd1;
  localparam logic [1:0] REQ_DEBUG = 2'd2;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  function automatic logic [1:0] onehot_to_idx(logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = REQ_CACHE;
    if (oh[1]) idx = REQ_STORE;
    if (oh[2]) idx = REQ_DEBUG;
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from last_winner+1
// (mod 3) and returns the first requesting index as a one-hot vector.
module rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_winner,
  output logic [NREQ-1:0] pick
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] sel;

  // rot[0] is always the highest-priority candidate for this round.
  always_comb begin
    rot = req;
    case (last_winner)
      REQ_CACHE: rot = {req[0], req[2], req[1]};
      REQ_STORE: rot = {req[1], req[0], req[2]};
      default:   rot = req;
    endcase
  end

  always_comb begin
    sel = '0;
    if (rot[0])      sel = 3'b001;
    else if (rot[1]) sel = 3'b010;
    else if (rot[2]) sel = 3'b100;
  end

  always_comb begin
    pick = sel;
    case (last_winner)
      REQ_CACHE: pick = {sel[1], sel[0], sel[2]};
      REQ_STORE: pick = {sel[0], sel[2], sel[1]};
      default:   pick = sel;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the cache
// refill, store and debug paths; reads take LAT cycles, writes one.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [2:0]      req,
  input  logic [2:0]      req_we,
  input  logic [3*N-1:0]  req_addr,
  input  logic [3*N-1:0]  req_wd,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [N-1:0]    rdata,
  output logic [N-1:0]    A,
  output logic [N-1:0]    WD,
  output logic            WE,
  input  logic [N-1:0]    RD,
  output logic            busy
);

  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("LAT must be in 1..4");
  end

  state_e          state;
  logic [1:0]      last_winner;
  logic [1:0]      cnt;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] cur;
  logic            cur_we;
  logic [1:0]      win;
  logic [N-1:0]    sel_addr;
  logic [N-1:0]    sel_wd;

  rr_pick u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .pick        (pick)
  );

  always_comb begin
    win      = onehot_to_idx(pick);
    sel_addr = req_addr[N-1:0];
    sel_wd   = req_wd[N-1:0];
    case (win)
      REQ_STORE: begin
        sel_addr = req_addr[2*N-1:N];
        sel_wd   = req_wd[2*N-1:N];
      end
      REQ_DEBUG: begin
        sel_addr = req_addr[3*N-1:2*N];
        sel_wd   = req_wd[3*N-1:2*N];
      end
      default: ;
    endcase
  end

  assign busy = (state != StIdle) || (|req);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= StIdle;
      last_winner <= REQ_DEBUG;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      A           <= '0;
      WD          <= '0;
      WE          <= 1'b0;
      cur         <= '0;
      cur_we      <= 1'b0;
      cnt         <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      WE     <= 1'b0;
      case (state)
        StIdle: begin
          if (|req) begin
            gnt         <= pick;
            last_winner <= win;
            A           <= sel_addr;
            WD          <= sel_wd;
            WE          <= req_we[win];
            cur         <= pick;
            cur_we      <= req_we[win];
            cnt         <= '0;
            state       <= StAccess;
          end
        end
        StAccess: begin
          if (cur_we) begin
            state <= StIdle;
          end else if (cnt == 2'(LAT - 1)) begin
            rdata  <= RD;
            rvalid <= cur;
            state  <= StIdle;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: LAT=1 and LAT=3 arbiters share stimulus; grant and
// read-data expectations flow through scoreboard queues.
module tb_mem_port_arbiter;

  localparam int N = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [2:0]     req, req_we;
  logic [3*N-1:0] req_addr, req_wd;
  logic [N-1:0]   RD;
  logic [2:0]     g1, rv1, g3, rv3;
  logic [N-1:0]   rd1, a1, wd1, rd3, a3, wd3;
  logic           we1, we3, b1, b3;
  logic [N-1:0]   mem [256];

  typedef struct {
    logic [2:0]   who;
    logic [N-1:0] addr;
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;

  assign RD = mem[a1];
  always #5 CLK = ~CLK;

  mem_port_arbiter #(.N(N), .LAT(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wd(req_wd), .gnt(g1), .rvalid(rv1), .rdata(rd1), .A(a1), .WD(wd1),
    .WE(we1), .RD(RD), .busy(b1)
  );

  mem_port_arbiter #(.N(N), .LAT(3)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wd(req_wd), .gnt(g3), .rvalid(rv3), .rdata(rd3), .A(a3), .WD(wd3),
    .WE(we3), .RD(RD), .busy(b3)
  );

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    req = '0;
    req_we = '0;
    tick();
    tick();
    RESET = 1'b0;
    gq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    req = '0;
    tick();
    tick();
    n_tests++; if (g1 !== 3'b000) begin n_fail++; $display("FAIL rst_gnt got %b want 000", g1); end
    n_tests++; if (rv1 !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid got %b want 000", rv1); end
    n_tests++; if (rd1 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", rd1); end
    n_tests++; if (a1 !== 8'h00) begin n_fail++; $display("FAIL rst_A got %h want 00", a1); end
    n_tests++; if (wd1 !== 8'h00) begin n_fail++; $display("FAIL rst_WD got %h want 00", wd1); end
    n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL rst_WE got %b want 0", we1); end
    n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", b1); end
    n_tests++; if (g3 !== 3'b000) begin n_fail++; $display("FAIL rst_gnt3 got %b want 000", g3); end
    RESET = 1'b0;
  endtask

  task automatic test_read();
    exp_t e;
    int nrv = 0;
    mem[8'h12] = 8'h5A;
    req_addr[7:0] = 8'h12;
    req_we = 3'b000;
    req = 3'b001;
    gq.push_back('{3'b001, 8'h12, 8'h00, 1});
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_tests++; if (!(c == 1) && we1 !== 1'b0) begin n_fail++; $display("FAIL rd_we c%0d got %b want 0", c, we1); end
      if (g1 !== 3'b000) begin
        if (gq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rd_extra_gnt got %b want 000", g1);
        end else begin
          e = gq.pop_front();
          n_tests++; if (g1 !== e.who) begin n_fail++; $display("FAIL rd_gnt got %b want %b", g1, e.who); end
          n_tests++; if (c != e.cyc) begin n_fail++; $display("FAIL rd_gnt_cyc got %0d want %0d", c, e.cyc); end
          n_tests++; if (a1 !== e.addr) begin n_fail++; $display("FAIL rd_A got %h want %h", a1, e.addr); end
          rq.push_back('{e.who, e.addr, mem[e.addr], c + 1});
        end
        req = req & ~g1;
      end
      if (rv1 !== 3'b000) begin
        nrv++;
        if (rq.size() != 0) begin
          e = rq.pop_front();
          n_tests++; if (rv1 !== e.who) begin n_fail++; $display("FAIL rd_rvalid got %b want %b", rv1, e.who); end
          n_tests++; if (rd1 !== e.data) begin n_fail++; $display("FAIL rd_rdata got %h want %h", rd1, e.data); end
          n_tests++; if (c != e.cyc) begin n_fail++; $display("FAIL rd_rv_cyc got %0d want %0d", c, e.cyc); end
        end
      end
    end
    n_tests++; if (nrv != 1) begin n_fail++; $display("FAIL rd_rv_count got %0d want 1", nrv); end
    n_tests++; if (gq.size() != 0) begin n_fail++; $display("FAIL rd_missing_gnt got %0d left want 0", gq.size()); end
  endtask

  task automatic test_write();
    exp_t e;
    int nwe = 0, nwe3 = 0, nrv = 0;
    gq.delete();
    req_we = 3'b010;
    req_addr[15:8] = 8'h40;
    req_wd[15:8] = 8'h99;
    req = 3'b010;
    gq.push_back('{3'b010, 8'h40, 8'h99, 1});
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (g1 !== 3'b000) begin
        if (gq.size() != 0) begin
          e = gq.pop_front();
          n_tests++; if (g1 !== e.who) begin n_fail++; $display("FAIL wr_gnt got %b want %b", g1, e.who); end
          n_tests++; if (c != e.cyc) begin n_fail++; $display("FAIL wr_gnt_cyc got %0d want %0d", c, e.cyc); end
        end
        req = req & ~g1;
      end
      if (we1) begin
        nwe++;
        n_tests++; if (a1 !== 8'h40) begin n_fail++; $display("FAIL wr_A got %h want 40", a1); end
        n_tests++; if (wd1 !== 8'h99) begin n_fail++; $display("FAIL wr_WD got %h want 99", wd1); end
        n_tests++; if (c != 1) begin n_fail++; $display("FAIL wr_we_cyc got %0d want 1", c); end
      end
      if (we3) nwe3++;
      if ((rv1 | rv3) !== 3'b000) nrv++;
      if (c == 3) begin
        n_tests++; if (a1 !== 8'h40) begin n_fail++; $display("FAIL wr_A_hold got %h want 40", a1); end
      end
    end
    n_tests++; if (nwe != 1) begin n_fail++; $display("FAIL wr_we_count got %0d want 1", nwe); end
    n_tests++; if (nwe3 != 1) begin n_fail++; $display("FAIL wr_we3_count got %0d want 1", nwe3); end
    n_tests++; if (nrv != 0) begin n_fail++; $display("FAIL wr_rvalid_count got %0d want 0", nrv); end
    n_tests++; if (gq.size() != 0) begin n_fail++; $display("FAIL wr_missing_gnt got %0d left want 0", gq.size()); end
    req_we = 3'b000;
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    mem[8'h10] = 8'hA1;
    mem[8'h20] = 8'hB2;
    mem[8'h30] = 8'hC3;
    req_addr = {8'h30, 8'h20, 8'h10};
    req_we = 3'b000;
    req = 3'b111;
    gq.push_back('{3'b001, 8'h10, 8'h00, 1});
    gq.push_back('{3'b010, 8'h20, 8'h00, 3});
    gq.push_back('{3'b100, 8'h30, 8'h00, 5});
    gq.push_back('{3'b001, 8'h10, 8'h00, 7});
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (g1 !== 3'b000) begin
        if (gq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rr_extra_gnt got %b at %0d want none", g1, c);
        end else begin
          e = gq.pop_front();
          n_tests++; if (g1 !== e.who) begin n_fail++; $display("FAIL rr_gnt got %b want %b", g1, e.who); end
          n_tests++; if (c != e.cyc) begin n_fail++; $display("FAIL rr_gnt_cyc got %0d want %0d", c, e.cyc); end
          n_tests++; if (a1 !== e.addr) begin n_fail++; $display("FAIL rr_A got %h want %h", a1, e.addr); end
          rq.push_back('{e.who, e.addr, mem[e.addr], c + 1});
        end
      end
      if (rv1 !== 3'b000) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rr_extra_rvalid got %b want 000", rv1);
        end else begin
          e = rq.pop_front();
          n_tests++; if (rv1 !== e.who) begin n_fail++; $display("FAIL rr_rvalid got %b want %b", rv1, e.who); end
          n_tests++; if (rd1 !== e.data) begin n_fail++; $display("FAIL rr_rdata got %h want %h", rd1, e.data); end
          n_tests++; if (c != e.cyc) begin n_fail++; $display("FAIL rr_rv_cyc got %0d want %0d", c, e.cyc); end
        end
      end
      if (c == 7) req = 3'b000;
    end
    n_tests++; if (gq.size() != 0) begin n_fail++; $display("FAIL rr_missing_gnt got %0d left want 0", gq.size()); end
    n_tests++; if (rq.size() != 0) begin n_fail++; $display("FAIL rr_missing_rv got %0d left want 0", rq.size()); end
  endtask

  task automatic test_lat3();
    int nrv = 0;
    do_reset();
    mem[8'h55] = 8'hC3;
    req_addr[7:0] = 8'h55;
    req = 3'b001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (g3 !== 3'b000) begin
        n_tests++; if (g3 !== 3'b001) begin n_fail++; $display("FAIL l3_gnt got %b want 001", g3); end
        n_tests++; if (c != 1) begin n_fail++; $display("FAIL l3_gnt_cyc got %0d want 1", c); end
        req = req & ~g3;
      end
      if (c <= 3) begin
        n_tests++; if (a3 !== 8'h55) begin n_fail++; $display("FAIL l3_A c%0d got %h want 55", c, a3); end
        n_tests++; if (rv3 !== 3'b000) begin n_fail++; $display("FAIL l3_early_rv c%0d got %b want 000", c, rv3); end
      end
      if (rv3 !== 3'b000) begin
        nrv++;
        n_tests++; if (rv3 !== 3'b001) begin n_fail++; $display("FAIL l3_rvalid got %b want 001", rv3); end
        n_tests++; if (rd3 !== 8'hC3) begin n_fail++; $display("FAIL l3_rdata got %h want c3", rd3); end
        n_tests++; if (c != 4) begin n_fail++; $display("FAIL l3_rv_cyc got %0d want 4", c); end
      end
    end
    n_tests++; if (nrv != 1) begin n_fail++; $display("FAIL l3_rv_count got %0d want 1", nrv); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    req_we = 3'b010;
    req_addr[15:8] = 8'h40;
    req_wd[15:8] = 8'h99;
    req = 3'b010;
    tick();
    n_tests++; if (g1 !== 3'b010) begin n_fail++; $display("FAIL ab_gnt got %b want 010", g1); end
    n_tests++; if (we1 !== 1'b1) begin n_fail++; $display("FAIL ab_we_before got %b want 1", we1); end
    RESET = 1'b1;
    req_we = 3'b000;
    req = 3'b101;
    tick();
    n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL ab_we_after got %b want 0", we1); end
    n_tests++; if (g1 !== 3'b000) begin n_fail++; $display("FAIL ab_rst_dominates got %b want 000", g1); end
    n_tests++; if (rv1 !== 3'b000) begin n_fail++; $display("FAIL ab_rvalid got %b want 000", rv1); end
    RESET = 1'b0;
    tick();
    n_tests++; if (g1 !== 3'b001) begin n_fail++; $display("FAIL ab_next_gnt got %b want 001", g1); end
    n_tests++; if (g3 !== 3'b001) begin n_fail++; $display("FAIL ab_next_gnt3 got %b want 001", g3); end
    req = 3'b000;
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_ignored_pulse();
    int ng1 = 0, ng3 = 0;
    do_reset();
    req_we = 3'b000;
    req_addr[7:0] = 8'h12;
    req = 3'b001;
    tick();
    n_tests++; if (g1 !== 3'b001) begin n_fail++; $display("FAIL ip_gnt got %b want 001", g1); end
    req = 3'b100;
    tick();
    req = 3'b000;
    n_tests++; if (rv1 !== 3'b001) begin n_fail++; $display("FAIL ip_rvalid got %b want 001", rv1); end
    for (int c = 2; c <= 7; c++) begin
      if (g1 !== 3'b000) ng1++;
      if (g3 !== 3'b000) ng3++;
      tick();
    end
    n_tests++; if (ng1 != 0) begin n_fail++; $display("FAIL ip_no_gnt got %0d grants want 0", ng1); end
    n_tests++; if (ng3 != 0) begin n_fail++; $display("FAIL ip_no_gnt3 got %0d grants want 0", ng3); end
  endtask

  initial begin
    RESET = 1'b1;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wd = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3C);
    @(negedge CLK);
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_lat3();
    test_reset_abort();
    test_ignored_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, giving the data and address width.
REQ-002 SHALL have parameter LAT, default 1, legal range 1..4, giving the memory read latency in cycles from A stable to RD valid.
REQ-003 SHALL have port CLK, input, 1 bit: clock, all state updates on posedge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, 3 bits: per-requester access request; index 0 is cache refill, 1 is store path, 2 is debug.
REQ-006 SHALL have port req_we, input, 3 bits: per-requester write (1) or read (0).
REQ-007 SHALL have port req_addr, input, 3xN bits: per-requester address.
REQ-008 SHALL have port req_wd, input, 3xN bits: per-requester write data.
REQ-009 SHALL have port gnt, output, 3 bits: one-hot, one-cycle grant pulse.
REQ-010 SHALL have port rvalid, output, 3 bits: one-hot, one-cycle read-data-valid pulse.
REQ-011 SHALL have port rdata, output, N bits: read data, valid while any rvalid bit is set.
REQ-012 SHALL have port A, output, N bits: memory address.
REQ-013 SHALL have port WD, output, N bits: memory write data.
REQ-014 SHALL have port WE, output, 1 bit: memory write enable.
REQ-015 SHALL have port RD, input, N bits: memory read data.
REQ-016 SHALL have port busy, output, 1 bit: high when state is not IDLE or any req bit is set.

Function
REQ-017 SHALL implement the FSM states IDLE and ACCESS.
REQ-018 In IDLE with any req bit set, SHALL on the next edge do all of the following: pick a winner round-robin, latch its addr, we and wd, set gnt[winner] for exactly the following cycle, and enter ACCESS.
REQ-019 Round-robin SHALL search from last_winner+1 modulo 3 upward; last_winner updates on each grant.
REQ-020 In ACCESS, A and WD SHALL present the latched values and stay stable for the entire state.
REQ-021 A write SHALL assert WE for exactly one cycle, the first ACCESS cycle, then return to IDLE; write transactions SHALL never assert rvalid.
REQ-022 A read SHALL hold ACCESS for LAT cycles with WE=0, then sample RD into rdata on the final edge.
REQ-023 On that same final edge, a read SHALL assert rvalid[winner] for the following cycle and return to IDLE.
REQ-024 A requester SHALL hold req until it sees gnt; a req deasserted before grant SHALL be ignored.
REQ-025 Once granted, the transaction SHALL complete regardless of later changes to req or its data.
REQ-026 In the IDLE cycle carrying rvalid, a new request SHALL be accepted, giving a back-to-back period of LAT+1 cycles per read.
REQ-027 Simultaneous requests SHALL be served one per transaction; no requester SHALL wait more than 2 transactions.
REQ-028 Outside a write ACCESS cycle, WE SHALL be 0.
REQ-029 A and WD SHALL hold their last values in IDLE.

Reset
REQ-030 On RESET, all of the following SHALL hold on the next edge: state=IDLE, last_winner=2, gnt=0, rvalid=0, rdata=0, A=0, WD=0, WE=0.
REQ-031 RESET during ACCESS SHALL abort the transaction, with WE=0 and no rvalid in the following cycle.
REQ-032 RESET SHALL dominate any simultaneous request.

Structure
REQ-033 The shared package SHALL hold the state enum, the requester indices (REQ_CACHE=0, REQ_STORE=1, REQ_DEBUG=2) and NREQ=3.
REQ-034 SHALL use one sub-module, rr_pick: a combinational round-robin selector with inputs req and last_winner and a one-hot output.

Verification
REQ-035 LAT=1, req[0] read addr 0x12, RD=0x5A -> gnt[0] at cycle 1, A=0x12 at cycle 1, rvalid[0] with rdata=0x5A at cycle 2.
REQ-036 req[1] write addr 0x40 data 0x99 -> WE=1 for exactly one cycle with A=0x40, WD=0x99, and no rvalid.
REQ-037 All three req held as reads, LAT=1 -> grants in order 0,1,2,0 at cycles 1,3,5,7.
REQ-038 LAT=3, read -> A stable 3 cycles, rvalid 3 cycles after gnt.
REQ-039 RESET asserted in the write ACCESS cycle -> WE=0 the next cycle, state IDLE; the next grant goes to requester 0.
REQ-040 req[2] pulsed for 1 cycle while busy serving requester 0 -> no gnt[2] issued.
